// File: rtl/keypad_emulator.sv
// keypad_emulator
//  Pretends to be a human on a 4x4 X/Y key matrix. Key codes are queued
//  through a valid/ready port; each queued key is held for HOLD_CYCLES and
//  then released for GAP_CYCLES. While a key is held, the block watches
//  which side of the matrix the scanner energises (all four lines high)
//  and drives the pressed key's line on the opposite side.
//
// Ports
//  Clk       clock, everything on posedge
//  Reset     synchronous active-high reset
//  KeyValid  KeyCode offered
//  KeyCode   key code 0x0-0xF
//  KeyReady  queue not full; write when KeyValid && KeyReady
//  XIn/YIn   matrix lines as read from the pads (asynchronous)
//  XOut/XOe  X pad drive value / enable
//  YOut/YOe  Y pad drive value / enable
//  Pressed   a key is currently held
//  Busy      queue non-empty or a press/gap in progress
//  Level     queue occupancy
module keypad_emulator #(
  parameter int HOLD_CYCLES = 50000,
  parameter int GAP_CYCLES  = 50000,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         KeyValid,
  input  logic [3:0]                   KeyCode,
  output logic                         KeyReady,
  input  logic [3:0]                   XIn,
  input  logic [3:0]                   YIn,
  output logic [3:0]                   XOut,
  output logic                         XOe,
  output logic [3:0]                   YOut,
  output logic                         YOe,
  output logic                         Pressed,
  output logic                         Busy,
  output logic [$clog2(FIFO_DEPTH):0]  Level
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int LW   = AW + 1;
  localparam int TMAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  // timer counts down from N-1 to 0, so it never holds TMAX itself
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  typedef enum logic [1:0] {IDLE, START, PRESS, GAP} state_t;

  state_t          state;
  logic [TW-1:0]   timer;
  logic [3:0]      cur;
  logic [3:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wp, rp;
  logic [3:0]      head;
  logic            push, pop, empty;
  logic [3:0]      xs1, xs, ys1, ys;

  // Column (X) line for a key, leftmost column is bit 3.
  function automatic logic [3:0] key_col(input logic [3:0] k);
    case (k)
      4'h1, 4'h4, 4'h7, 4'hE: key_col = 4'b1000;
      4'h2, 4'h5, 4'h8, 4'h0: key_col = 4'b0100;
      4'h3, 4'h6, 4'h9, 4'hF: key_col = 4'b0010;
      default:                key_col = 4'b0001; // A B C D
    endcase
  endfunction

  // Row (Y) line for a key, top row is bit 3.
  function automatic logic [3:0] key_row(input logic [3:0] k);
    case (k)
      4'h1, 4'h2, 4'h3, 4'hA: key_row = 4'b1000;
      4'h4, 4'h5, 4'h6, 4'hB: key_row = 4'b0100;
      4'h7, 4'h8, 4'h9, 4'hC: key_row = 4'b0010;
      default:                key_row = 4'b0001; // E 0 F D
    endcase
  endfunction

  // Pad drive for a held key given the synchronised matrix state.
  // Returns {XOe, XOut, YOe, YOut}; only one side is ever enabled.
  function automatic logic [9:0] drive(input logic [3:0] k,
                                       input logic [3:0] x,
                                       input logic [3:0] y);
    drive = '0;
    if (x == 4'hF && y != 4'hF)      drive = {1'b0, 4'h0, 1'b1, key_row(k)};
    else if (y == 4'hF && x != 4'hF) drive = {1'b1, key_col(k), 1'b0, 4'h0};
  endfunction

  // ---------------- key queue ----------------
  assign empty    = (Level == '0);
  assign KeyReady = (Level != LW'(FIFO_DEPTH));
  assign push     = KeyValid && KeyReady;
  assign head     = mem[rp];
  // Pops happen only when the FSM is about to start a new press.
  assign pop      = !empty && ((state == IDLE) || (state == GAP && timer == '0));
  assign Busy     = (state != IDLE) || !empty;

  always_ff @(posedge Clk) begin
    if (push) mem[wp] <= KeyCode;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      wp    <= '0;
      rp    <= '0;
      Level <= '0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop)  rp <= rp + AW'(1);
      Level <= Level + LW'(push) - LW'(pop);
    end
  end

  // ---------------- press FSM + pad drive ----------------
  // START is a one-cycle stage after the first pop from IDLE, so Pressed
  // lines up with state==PRESS. Back-to-back keys skip it (GAP -> PRESS)
  // so the release gap stays exactly GAP_CYCLES long. The pad drive is
  // written in the same branches as Pressed so both enables drop on the
  // same edge as Pressed.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= IDLE;
      timer   <= '0;
      cur     <= '0;
      Pressed <= 1'b0;
      xs1     <= '0;
      xs      <= '0;
      ys1     <= '0;
      ys      <= '0;
      {XOe, XOut, YOe, YOut} <= '0;
    end else begin
      xs1 <= XIn;
      xs  <= xs1;
      ys1 <= YIn;
      ys  <= ys1;
      {XOe, XOut, YOe, YOut} <= '0;
      case (state)
        IDLE: begin
          if (pop) begin
            cur   <= head;
            state <= START;
          end
        end
        START: begin
          state   <= PRESS;
          Pressed <= 1'b1;
          timer   <= TW'(HOLD_CYCLES - 1);
          {XOe, XOut, YOe, YOut} <= drive(cur, xs, ys);
        end
        PRESS: begin
          if (timer == '0) begin
            state   <= GAP;
            Pressed <= 1'b0;
            timer   <= TW'(GAP_CYCLES - 1);
          end else begin
            timer <= timer - TW'(1);
            {XOe, XOut, YOe, YOut} <= drive(cur, xs, ys);
          end
        end
        GAP: begin
          if (timer == '0) begin
            if (pop) begin
              cur     <= head;
              state   <= PRESS;
              Pressed <= 1'b1;
              timer   <= TW'(HOLD_CYCLES - 1);
              {XOe, XOut, YOe, YOut} <= drive(head, xs, ys);
            end else begin
              state <= IDLE;
            end
          end else begin
            timer <= timer - TW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_emulator.sv
module tb_keypad_emulator;

  localparam int H  = 24;
  localparam int G  = 4;
  localparam int H6 = 3;
  localparam int G6 = 2;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       KeyValid;
  logic [3:0] KeyCode;
  logic       KeyReady;
  logic [3:0] XIn, YIn, XOut, YOut;
  logic       XOe, YOe, Pressed, Busy;
  logic [3:0] Level;

  logic       kv6;
  logic [3:0] kc6;
  logic [3:0] x6, y6, xo6, yo6;
  logic       kr6, xoe6, yoe6, pr6, busy6;
  logic [3:0] lvl6;

  int n_cmp = 0;
  int n_err = 0;
  logic [3:0] sb[$];

  always #5 Clk = ~Clk;

  keypad_emulator #(.HOLD_CYCLES(H), .GAP_CYCLES(G), .FIFO_DEPTH(8)) dut (
    .Clk(Clk), .Reset(Reset), .KeyValid(KeyValid), .KeyCode(KeyCode),
    .KeyReady(KeyReady), .XIn(XIn), .YIn(YIn), .XOut(XOut), .XOe(XOe),
    .YOut(YOut), .YOe(YOe), .Pressed(Pressed), .Busy(Busy), .Level(Level));

  keypad_emulator #(.HOLD_CYCLES(H6), .GAP_CYCLES(G6), .FIFO_DEPTH(8)) dut6 (
    .Clk(Clk), .Reset(Reset), .KeyValid(kv6), .KeyCode(kc6),
    .KeyReady(kr6), .XIn(x6), .YIn(y6), .XOut(xo6), .XOe(xoe6),
    .YOut(yo6), .YOe(yoe6), .Pressed(pr6), .Busy(busy6), .Level(lvl6));

  task automatic step(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Key layout as printed on the keypad: [row][col], top-left first.
  function automatic logic [3:0] decode(input logic [3:0] row, input logic [3:0] col);
    logic [3:0] kmap [4][4];
    logic [3:0] lb;
    kmap = '{'{4'h1, 4'h2, 4'h3, 4'hA},
             '{4'h4, 4'h5, 4'h6, 4'hB},
             '{4'h7, 4'h8, 4'h9, 4'hC},
             '{4'hE, 4'h0, 4'hF, 4'hD}};
    decode = 4'hx;
    lb = 4'b1000;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (row == (lb >> r) && col == (lb >> c)) decode = kmap[r][c];
  endfunction

  task automatic wait_pressed(input logic lvl, input string tag);
    int t = 0;
    while (Pressed !== lvl && t < 400) begin step(1); t++; end
    chk(tag, Pressed, lvl);
  endtask

  task automatic wait_idle(input string tag);
    int t = 0;
    while (Busy !== 1'b0 && t < 400) begin step(1); t++; end
    chk(tag, Busy, 1'b0);
  endtask

  // Scanner model: energise X, read the row; energise Y, read the column;
  // decode and compare with the oldest key still expected.
  task automatic scan_key();
    logic [3:0] row, col, key, exp;
    logic down;
    wait_pressed(1'b1, "press_rise");
    XIn = 4'hF; YIn = 4'h0;
    step(4);
    chk("yoe_xphase", YOe, 1'b1);
    chk("xoe_xphase", XOe, 1'b0);
    row = YOut;
    XIn = 4'h0; YIn = 4'hF;
    step(4);
    chk("xoe_yphase", XOe, 1'b1);
    chk("yoe_yphase", YOe, 1'b0);
    col  = XOut;
    down = Pressed;
    key  = decode(row, col);
    if (sb.size() == 0) begin
      chk("sb_nonempty", 32'd0, 32'd1);
    end else begin
      exp = sb.pop_front();
      chk("button", key, exp);
    end
    chk("down", down, 1'b1);
    wait_pressed(1'b0, "press_fall");
    XIn = 4'h0; YIn = 4'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, n, cyc;
    logic [3:0] codes [9];
    Reset = 1'b1; KeyValid = 1'b0; KeyCode = 4'h0; XIn = 4'h0; YIn = 4'h0;
    kv6 = 1'b0; kc6 = 4'h0; x6 = 4'h0; y6 = 4'h0;
    step(2);
    Reset = 1'b0;

    // reset state
    chk("rst_keyready", KeyReady, 1'b1);
    chk("rst_xoe", XOe, 1'b0);
    chk("rst_yoe", YOe, 1'b0);
    chk("rst_xout", XOut, 4'h0);
    chk("rst_yout", YOut, 4'h0);
    chk("rst_pressed", Pressed, 1'b0);
    chk("rst_busy", Busy, 1'b0);
    chk("rst_level", Level, 4'd0);

    // key 5 with X energised: first-press latency and hold/gap lengths
    XIn = 4'hF; YIn = 4'h0;
    step(3);
    KeyValid = 1'b1; KeyCode = 4'h5;
    step(1);
    KeyValid = 1'b0;
    chk("t1_level_after_accept", Level, 4'd1);
    chk("t1_busy_after_accept", Busy, 1'b1);
    chk("t1_pressed_e0", Pressed, 1'b0);
    step(1);
    chk("t1_pressed_e1", Pressed, 1'b0);
    chk("t1_level_after_pop", Level, 4'd0);
    step(1);
    chk("t1_pressed_e2", Pressed, 1'b1);
    chk("t1_yoe", YOe, 1'b1);
    chk("t1_yout", YOut, 4'b0100);
    chk("t1_xoe", XOe, 1'b0);
    cnt = 0;
    while (Pressed === 1'b1 && cnt < 200) begin step(1); cnt++; end
    chk("t1_hold_len", cnt, H);
    chk("t1_yoe_on_release", YOe, 1'b0);
    cnt = 0;
    while (Busy === 1'b1 && cnt < 200) begin step(1); cnt++; end
    chk("t1_gap_len", cnt, G);
    XIn = 4'h0;

    // key D read by the scanner model
    sb.push_back(4'hD);
    KeyValid = 1'b1; KeyCode = 4'hD;
    step(1);
    KeyValid = 1'b0;
    scan_key();
    wait_idle("t2_idle");

    // fill the queue back-to-back, then replay in order
    for (int i = 0; i < 9; i++) codes[i] = 4'(i + 1);
    n = 0; cyc = 0;
    while (n < 9 && cyc < 20) begin
      if (KeyReady === 1'b1) begin
        KeyValid = 1'b1; KeyCode = codes[n];
        sb.push_back(codes[n]);
        n++;
      end else begin
        KeyValid = 1'b0;
      end
      step(1);
      cyc++;
    end
    KeyValid = 1'b0;
    chk("t3_accepted", n, 9);
    chk("t3_back_to_back", cyc, 9);
    chk("t3_level_full", Level, 4'd8);
    chk("t3_keyready_full", KeyReady, 1'b0);
    for (int i = 0; i < 9; i++) scan_key();
    chk("t3_sb_drained", sb.size(), 0);
    wait_idle("t3_idle");

    // both sides all-ones, then neither: no drive
    XIn = 4'hF; YIn = 4'hF;
    KeyValid = 1'b1; KeyCode = 4'h7;
    step(1);
    KeyValid = 1'b0;
    wait_pressed(1'b1, "t4_press");
    step(4);
    chk("t4_both_xoe", XOe, 1'b0);
    chk("t4_both_yoe", YOe, 1'b0);
    chk("t4_both_xout", XOut, 4'h0);
    XIn = 4'h0; YIn = 4'h0;
    step(4);
    chk("t4_none_xoe", XOe, 1'b0);
    chk("t4_none_yoe", YOe, 1'b0);
    chk("t4_still_pressed", Pressed, 1'b1);
    wait_idle("t4_idle");

    // reset mid-press with 3 keys queued
    XIn = 4'hF;
    for (int i = 0; i < 4; i++) begin
      KeyValid = 1'b1; KeyCode = 4'(i + 1);
      step(1);
    end
    KeyValid = 1'b0;
    wait_pressed(1'b1, "t5_press");
    step(8);
    chk("t5_level_before", Level, 4'd3);
    chk("t5_yoe_before", YOe, 1'b1);
    Reset = 1'b1;
    step(1);
    chk("t5_pressed", Pressed, 1'b0);
    chk("t5_xoe", XOe, 1'b0);
    chk("t5_yoe", YOe, 1'b0);
    chk("t5_level", Level, 4'd0);
    chk("t5_keyready", KeyReady, 1'b1);
    chk("t5_busy", Busy, 1'b0);
    Reset = 1'b0;
    XIn = 4'h0;
    step(2);

    // short timing instance: keys 1 and E, Pressed/Busy per cycle
    kv6 = 1'b1; kc6 = 4'h1;
    step(1);
    kc6 = 4'hE;
    for (int k = 1; k <= 16; k++) begin
      step(1);
      kv6 = 1'b0;
      chk($sformatf("t6_pressed_k%0d", k), pr6,
          ((k >= 2 && k < 2 + H6) || (k >= 2 + H6 + G6 && k < 2 + 2*H6 + G6)) ? 1'b1 : 1'b0);
      chk($sformatf("t6_busy_k%0d", k), busy6, (k < 2 + 2*H6 + 2*G6) ? 1'b1 : 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
